// File: rtl/xnor_gate_sync.sv
// Registered bitwise XNOR (equivalence) cell with an all-bits-equal flag and a
// popcount of matching bit positions; every output is a flop, latency one cycle.
module xnor_gate_sync #(
  parameter int WIDTH = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             all_match,
  output logic [CNT_W-1:0] match_count
);

  logic [WIDTH-1:0] eq;
  logic [CNT_W-1:0] eq_count;

  assign eq = ~(a ^ b);

  always_comb begin
    // NOTE: eq_count is defaulted before the loop so every path assigns it and no latch is inferred.
    eq_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      eq_count = eq_count + CNT_W'(eq[i]);
    end
  end

  // Data registers load only on an accepted input, so unknown operands presented
  // while in_valid is low never reach the outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (!rst_n) begin
      y           <= '0;
      out_valid   <= 1'b0;
      all_match   <= 1'b0;
      match_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y           <= eq;
        all_match   <= &eq;
        match_count <= eq_count;
      end
    end
  end

endmodule

// File: tb/tb_xnor_gate_sync.sv
// Self-checking bench for xnor_gate_sync at WIDTH 1, 8 and 16 against a
// bit-comparison reference model kept in the bench.
module tb_xnor_gate_sync;

  logic clk;
  logic rst_n;

  logic        v1,  a1,  b1,  y1,  ov1,  am1;
  logic [0:0]  mc1;
  logic        v8,  ov8,  am8;
  logic [7:0]  a8,  b8,  y8;
  logic [3:0]  mc8;
  logic        v16, ov16, am16;
  logic [15:0] a16, b16, y16;
  logic [4:0]  mc16;

  int n_cmp = 0;
  int n_bad = 0;

  xnor_gate_sync #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .y(y1), .out_valid(ov1), .all_match(am1), .match_count(mc1)
  );

  xnor_gate_sync #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .y(y8), .out_valid(ov8), .all_match(am8), .match_count(mc8)
  );

  xnor_gate_sync #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16),
    .y(y16), .out_valid(ov16), .all_match(am16), .match_count(mc16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a bit matches when both operands carry the same value there.
  function automatic logic [63:0] ref_eq(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) r[i] = (a[i] == b[i]);
    return r;
  endfunction

  function automatic int ref_matches(input logic [63:0] a, input logic [63:0] b, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) if (a[i] == b[i]) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [63:0] ey, input logic eov,
                      input logic eam, input int ecnt);
    check({tag, ".y"},   64'(y1),  ey);
    check({tag, ".ov"},  64'(ov1), 64'(eov));
    check({tag, ".am"},  64'(am1), 64'(eam));
    check({tag, ".cnt"}, 64'(mc1), 64'(ecnt));
  endtask

  task automatic chk8(input string tag, input logic [63:0] ey, input logic eov,
                      input logic eam, input int ecnt);
    check({tag, ".y"},   64'(y8),  ey);
    check({tag, ".ov"},  64'(ov8), 64'(eov));
    check({tag, ".am"},  64'(am8), 64'(eam));
    check({tag, ".cnt"}, 64'(mc8), 64'(ecnt));
  endtask

  task automatic chk16(input string tag, input logic [63:0] ey, input logic eov,
                       input logic eam, input int ecnt);
    check({tag, ".y"},   64'(y16),  ey);
    check({tag, ".ov"},  64'(ov16), 64'(eov));
    check({tag, ".am"},  64'(am16), 64'(eam));
    check({tag, ".cnt"}, 64'(mc16), 64'(ecnt));
  endtask

  logic [7:0] vec_a [3] = '{8'hA5, 8'hF0, 8'hAA};
  logic [7:0] vec_b [3] = '{8'hA5, 8'h0F, 8'hA5};
  logic [7:0] vec_y [3] = '{8'hFF, 8'h00, 8'hF0};
  logic       vec_m [3] = '{1'b1, 1'b0, 1'b0};
  int         vec_c [3] = '{8, 0, 4};

  logic [63:0] ey16;
  logic        eam16;
  int          ecnt16;

  initial begin
    // Reset held two cycles while every instance is offered an all-equal input.
    rst_n = 1'b0;
    v1 = 1'b1;  a1 = 1'b1;   b1 = 1'b1;
    v8 = 1'b1;  a8 = 8'hFF;  b8 = 8'hFF;
    v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      step();
      chk1("rst_w1", 64'h0, 1'b0, 1'b0, 0);
      chk8("rst_w8", 64'h0, 1'b0, 1'b0, 0);
      chk16("rst_w16", 64'h0, 1'b0, 1'b0, 0);
    end
    rst_n = 1'b1;
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;

    // WIDTH=1 truth table, back to back.
    v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ab;
      ab = 2'(k);
      a1 = ab[1];
      b1 = ab[0];
      step();
      chk1($sformatf("tt%0d%0d", ab[1], ab[0]), ref_eq(64'(ab[1]), 64'(ab[0]), 1), 1'b1,
           (ab[1] == ab[0]), ref_matches(64'(ab[1]), 64'(ab[0]), 1));
    end
    v1 = 1'b0;
    step();
    chk1("w1_idle", 64'h1, 1'b0, 1'b1, 1);

    // WIDTH=8 directed vectors, back to back.
    v8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a8 = vec_a[k];
      b8 = vec_b[k];
      step();
      chk8($sformatf("vec%0d", k), 64'(vec_y[k]), 1'b1, vec_m[k], vec_c[k]);
    end

    // Accept once, then hold for three idle cycles with junk operands.
    a8 = 8'h3C; b8 = 8'h3C;
    step();
    chk8("hold_acc", 64'hFF, 1'b1, 1'b1, 8);
    v8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (c == 2) begin
        a8 = 'x;
        b8 = 'x;
      end
      step();
      chk8($sformatf("hold%0d", c), 64'hFF, 1'b0, 1'b1, 8);
    end

    // Reset in the middle of a continuous stream.
    v8 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      step();
      chk8($sformatf("pre%0d", c), ref_eq(64'(a8), 64'(b8), 8), 1'b1,
           (a8 == b8), ref_matches(64'(a8), 64'(b8), 8));
    end
    rst_n = 1'b0;
    a8 = 8'h5A; b8 = 8'h5A;
    step();
    chk8("mid_rst", 64'h0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    a8 = 8'h01; b8 = 8'h00;
    step();
    chk8("post_rst", 64'hFE, 1'b1, 1'b0, 7);
    v8 = 1'b0;

    // Randomized WIDTH=16 stream; instance has seen nothing but resets so far.
    ey16 = '0; eam16 = 1'b0; ecnt16 = 0;
    for (int c = 0; c < 1000; c++) begin
      int sel;
      v16 = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      b16 = a16;
      else if (sel == 1) b16 = a16 ^ (16'h1 << $urandom_range(0, 15));
      else if (sel == 2) b16 = ~a16;
      else               b16 = 16'($urandom);
      if (v16) begin
        ey16   = ref_eq(64'(a16), 64'(b16), 16);
        ecnt16 = ref_matches(64'(a16), 64'(b16), 16);
        eam16  = (ecnt16 == 16);
      end
      step();
      chk16("rnd", ey16, v16, eam16, ecnt16);
    end
    v16 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
